// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath: FETCH -> DECODE -> EXECUTE -> [MEM] -> [WB].
// Handshakes with wait-state instruction/data memories, traps on a data-memory timeout.
// Optional performance counters are built only when PERF_CNT_EN is defined.
module multicycle_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ready,
  input  logic             dec_write_reg,
  input  logic             dec_write_mem,
  input  logic             dec_mem_to_reg,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             rf_we,
  output logic             pc_we,
  output logic             retire,
  output logic             trap,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    StFetch   = 3'd0,
    StDecode  = 3'd1,
    StExecute = 3'd2,
    StMem     = 3'd3,
    StWb      = 3'd4,
    StTrap    = 3'd5
  } state_e;

  localparam int unsigned TmoW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  // Count value seen during the last permitted MEM cycle
  localparam logic [TmoW-1:0] TmoLast = TmoW'(MEM_TIMEOUT - 1);

  state_e          state_q;
  logic            f_write_reg;
  logic            f_write_mem;
  logic            f_mem_to_reg;
  logic [TmoW-1:0] tmo_cnt;
  logic            trap_q;

  // FSM state, latched decoder flags, MEM timeout counter and sticky trap
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StFetch;
      f_write_reg  <= 1'b0;
      f_write_mem  <= 1'b0;
      f_mem_to_reg <= 1'b0;
      tmo_cnt      <= '0;
      trap_q       <= 1'b0;
    end else begin
      case (state_q)
        StFetch: begin
          if (imem_ready) state_q <= StDecode;
        end
        StDecode: begin
          f_write_reg  <= dec_write_reg;
          f_write_mem  <= dec_write_mem;
          f_mem_to_reg <= dec_mem_to_reg;
          state_q      <= StExecute;
        end
        StExecute: begin
          if (f_write_mem || f_mem_to_reg) begin
            state_q <= StMem;
            tmo_cnt <= '0;
          end else if (f_write_reg) begin
            state_q <= StWb;
          end else begin
            state_q <= StFetch;
          end
        end
        StMem: begin
          if (dmem_ready) begin
            // Store takes priority over load when both flags are set
            state_q <= f_write_mem ? StFetch : StWb;
          end else if ((MEM_TIMEOUT != 0) && (tmo_cnt == TmoLast)) begin
            state_q <= StTrap;
            trap_q  <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + TmoW'(1);
          end
        end
        StWb:    state_q <= StFetch;
        StTrap:  state_q <= StTrap;
        default: state_q <= StFetch;
      endcase
    end
  end

  // Strobes decoded from state and memory handshakes; all held low during reset
  always_comb begin
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    if (!rst) begin
      case (state_q)
        StFetch: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        StExecute: begin
          if (!f_write_mem && !f_mem_to_reg && !f_write_reg) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        StMem: begin
          dmem_req = 1'b1;
          dmem_we  = f_write_mem;
          if (dmem_ready && f_write_mem) begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end
        StWb: begin
          rf_we  = 1'b1;
          pc_we  = 1'b1;
          retire = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap  = trap_q;
  assign state = state_q;

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] cycle_q;
  logic [CNT_W-1:0] retired_q;

  // Free-running cycle counter and retired-instruction counter, both wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      retired_q <= '0;
    end else begin
      cycle_q <= cycle_q + CNT_W'(1);
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  assign cycle_cnt   = cycle_q;
  assign retired_cnt = retired_q;
`else
  assign cycle_cnt   = '0;
  assign retired_cnt = '0;
`endif

endmodule
